// File: rtl/iro_pkg.sv
// Shared constants and FSM state type for the ring-oscillator measurement sequencer.
package iro_pkg;

    localparam int IRO_N_STAGES = 25;
    localparam int PHASE_W      = 16;
    localparam int NSEL_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_HOLD,
        ST_FINISH
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/iro_phase_sync.sv
// Free-running multi-flop synchronizer for the asynchronous ring phase taps.
module iro_phase_sync #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             bclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_d[gi] = async_in;
        end else begin : g_tail
            assign stage_d[gi] = stage_q[gi-1];
        end
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign sync_out = stage_q[STAGES-1];

endmodule

// File: rtl/iro_sequencer.sv
// Measurement sequencer for the instrumented ring oscillator: seed load, settle,
// timed run, phase capture and hold. Every pin towards the ring is a flop output.
module iro_sequencer
    import iro_pkg::*;
#(
    parameter int N_STAGES      = IRO_N_STAGES,
    parameter int RUN_W         = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                bclk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [N_STAGES-1:0] seed_in,
    input  logic [NSEL_W-1:0]   n_stages_in,
    input  logic [RUN_W-1:0]    run_cycles,
    output logic                busy,
    output logic                done,
    output logic [PHASE_W-1:0]  capture,
    output logic                iro_sclk,
    output logic                iro_sdat,
    output logic                iro_enable,
    output logic                iro_hold,
    output logic [NSEL_W-1:0]   iro_n_stages,
    input  logic [PHASE_W-1:0]  iro_phases
);

    localparam int CNT_MAX = max_int(max_int(2 * N_STAGES, SETTLE_CYCLES),
                                     max_int(2 ** RUN_W, HOLD_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_STAGES-1:0]  seed_q, seed_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [NSEL_W-1:0]    n_stages_q, n_stages_d;
    logic [PHASE_W-1:0]   capture_q, capture_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sclk_q, sclk_d;
    logic                 sdat_q, sdat_d;
    logic                 enable_q, enable_d;
    logic                 hold_q, hold_d;
    logic [PHASE_W-1:0]   phases_sync;

    iro_phase_sync #(
        .WIDTH  (PHASE_W),
        .STAGES (SYNC_STAGES)
    ) u_phase_sync (
        .bclk     (bclk),
        .rst_n    (rst_n),
        .async_in (iro_phases),
        .sync_out (phases_sync)
    );

    // Outputs are computed from the current state, so the pins lag the state by one cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seed_d     = seed_q;
        run_d      = run_q;
        n_stages_d = n_stages_q;
        capture_d  = capture_q;
        busy_d     = (state_q != ST_IDLE);
        done_d     = 1'b0;
        sclk_d     = 1'b0;
        sdat_d     = 1'b0;
        enable_d   = 1'b0;
        hold_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seed_d     = seed_in;
                    run_d      = (run_cycles == '0) ? RUN_W'(1) : run_cycles;
                    n_stages_d = n_stages_in;
                    cnt_d      = CNT_W'(2 * N_STAGES - 1);
                    state_d    = ST_LOAD;
                    busy_d     = 1'b1;
                end
            end
            ST_LOAD: begin
                // Odd down-count = low half of a bit slot, even = high half; shift after the high half.
                sclk_d = ~cnt_q[0];
                sdat_d = seed_q[N_STAGES-1];
                if (!cnt_q[0]) begin
                    seed_d = {seed_q[N_STAGES-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_W'(run_q) - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                enable_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d   = ST_HOLD;
                    capture_d = phases_sync;
                    cnt_d     = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                enable_d = 1'b1;
                hold_d   = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a start in the same cycle.
        if (abort) begin
            state_d    = ST_IDLE;
            seed_d     = seed_q;
            run_d      = run_q;
            n_stages_d = n_stages_q;
            capture_d  = capture_q;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            sclk_d     = 1'b0;
            sdat_d     = 1'b0;
            enable_d   = 1'b0;
            hold_d     = 1'b0;
        end
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            seed_q     <= '0;
            run_q      <= '0;
            n_stages_q <= '0;
            capture_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            sdat_q     <= 1'b0;
            enable_q   <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seed_q     <= seed_d;
            run_q      <= run_d;
            n_stages_q <= n_stages_d;
            capture_q  <= capture_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sclk_q     <= sclk_d;
            sdat_q     <= sdat_d;
            enable_q   <= enable_d;
            hold_q     <= hold_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign capture      = capture_q;
    assign iro_sclk     = sclk_q;
    assign iro_sdat     = sdat_q;
    assign iro_enable   = enable_q;
    assign iro_hold     = hold_q;
    assign iro_n_stages = n_stages_q;

endmodule
